sd_card_detect: RTL
===================

# sd_card_detect

Card-detect and write-protect front end for the SD host controller. Synchronises the raw card-detect and write-protect pins and debounces card presence. Produces the present-state levels (card inserted, card state stable, card detect pin level, write protect pin level) and one-cycle card insertion/removal event pulses. These feed the normal interrupt status logic, replacing the constant tie-offs currently in the top level.

## Interface

Parameters:
- `DebounceCycles`, default 65536: number of consecutive equal samples required to commit a card-presence change. Minimum 2; elaboration error below that.
- `SyncStages`, default 2: flip-flop stages on each raw pin. Minimum 2.

Ports:
- `clk_i`, in, 1: system clock; the single clock of the block.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `sd_cd_ni`, in, 1: raw card-detect pin, low = card present, asynchronous.
- `sd_wp_i`, in, 1: raw write-protect pin, asynchronous.
- `cd_test_sel_i`, in, 1: card detect signal selection from Host Control; 1 = use test level.
- `cd_test_level_i`, in, 1: card detect test level from Host Control; 1 = inserted.
- `card_inserted_o`, out, 1: debounced card presence.
- `card_state_stable_o`, out, 1: 1 when no debounce is in progress.
- `card_detect_pin_level_o`, out, 1: synchronised, undebounced, inverted `sd_cd_ni`.
- `write_protect_pin_level_o`, out, 1: synchronised `sd_wp_i`.
- `card_insertion_o`, out, 1: one-cycle pulse on a committed 0→1 change of `card_inserted_o`.
- `card_removal_o`, out, 1: one-cycle pulse on a committed 1→0 change.

## Operation

- Synchronisers:
  - `SyncStages` flops per pin.
  - The cd chain resets to 1 (no card); the wp chain resets to 0.
- Source sample `s`:
  - `s = cd_test_sel_i ? cd_test_level_i : !cd_sync`.
  - The test level is not synchronised but is debounced.
- State: committed level `ins_q`, counter `cnt_q` of width `$clog2(DebounceCycles+1)`, and an FSM with states SETTLE, STABLE, DEBOUNCE.
- SETTLE (entered on reset):
  - `ins_q`=0, `cnt_q`=0.
  - Each cycle, if `s` equals the previous cycle's `s`, increment; otherwise load 1.
  - When the count reaches `DebounceCycles`: `ins_q` ← `s`, `cnt_q` ← 0, go to STABLE, and pulse `card_insertion_o` if `s`=1. No pulse if `s`=0.
- STABLE:
  - `s`==`ins_q`: stay, `cnt_q`=0.
  - `s`!=`ins_q`: go to DEBOUNCE, `cnt_q` ← 1.
- DEBOUNCE:
  - `s`==`ins_q`: glitch rejected; go to STABLE, `cnt_q` ← 0, no pulse.
  - `s`!=`ins_q` and `cnt_q`==`DebounceCycles`-1: toggle `ins_q`, go to STABLE, `cnt_q` ← 0, and pulse insertion or removal per the new level.
  - Otherwise `cnt_q` increments.
- `card_state_stable_o` = (state == STABLE).
- Switching `cd_test_sel_i` is treated as an ordinary change of `s` and is debounced the same way.
- The counter never wraps; its maximum value is `DebounceCycles`.
- Insertion and removal are mutually exclusive and never asserted in back-to-back cycles, because a change needs at least 2 cycles.

## Timing

- Reset values: every output is 0; state SETTLE.
- Pin to level:
  - `card_detect_pin_level_o` and `write_protect_pin_level_o` follow the pins after `SyncStages` cycles.
  - They are not debounced.
- Commit latency:
  - `s` differs from `ins_q` for cycles n … n+`DebounceCycles`-1.
  - `card_inserted_o` and the event pulse are visible in cycle n+`DebounceCycles`. The pulse is high for exactly that cycle.
  - Latency from `sd_cd_ni` adds `SyncStages`.
- Stable flag: `card_state_stable_o` falls in cycle n+1 and rises together with the commit, or one cycle after a rejected glitch ends.
- After reset, with constant `s`: first commit in cycle `DebounceCycles`+1 after `rst_i` deasserts, given the synchronisers are already settled.
- Reset mid-operation: asynchronous. All outputs drop to 0 immediately, and no pulse is generated by reset itself.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan

Run all scenarios with `DebounceCycles`=4 and `SyncStages`=2.

- Reset with `sd_cd_ni`=1 held, then release:
  - `card_state_stable_o` rises within 7 cycles, with `card_inserted_o`=0.
  - No insertion or removal pulse.
- From stable absent, drive `sd_cd_ni`=0 at cycle t:
  - `card_detect_pin_level_o`=1 at t+2.
  - `card_inserted_o`=1 and a single-cycle `card_insertion_o` at t+6.
  - `card_state_stable_o`=0 for t+3 … t+5.
- Glitch: `sd_cd_ni`=0 for 3 cycles, then back to 1:
  - `card_inserted_o` stays 0.
  - No pulse.
  - `card_state_stable_o` dips, then returns to 1.
- Removal from stable present: `sd_cd_ni`=1 held, giving exactly one `card_removal_o` pulse and `card_inserted_o`=0 six cycles after the edge.
- Test mode:
  - `cd_test_sel_i`=1 with `cd_test_level_i`=1 while the pin shows absent: insertion pulse 4 cycles after select.
  - Toggling `sd_wp_i` only changes `write_protect_pin_level_o`, 2 cycles later.
- Assert `rst_i` during DEBOUNCE:
  - All outputs are 0 in the same cycle.
  - After release, a full SETTLE sequence occurs with no spurious removal pulse.

Source files
------------

// File: rtl/sd_card_detect.sv
// -----------------------------------------------------------------------------
// sd_card_detect
//
// Card-detect / write-protect front end for the SD host controller.
// Synchronises the raw card-detect and write-protect pins, debounces card
// presence and produces present-state levels plus one-cycle insertion and
// removal event pulses for the normal interrupt status logic.
//
// Parameters
//   DebounceCycles : consecutive equal samples needed to commit a presence
//                    change (>= 2)
//   SyncStages     : synchroniser depth on each raw pin (>= 2)
//
// Ports
//   clk_i                     : system clock
//   rst_i                     : asynchronous active-high reset
//   sd_cd_ni                  : raw card-detect pin, low = card present
//   sd_wp_i                   : raw write-protect pin
//   cd_test_sel_i             : 1 = use cd_test_level_i instead of the pin
//   cd_test_level_i           : test card-detect level, 1 = inserted
//   card_inserted_o           : debounced card presence
//   card_state_stable_o       : 1 when no debounce is in progress
//   card_detect_pin_level_o   : synchronised, inverted sd_cd_ni (undebounced)
//   write_protect_pin_level_o : synchronised sd_wp_i
//   card_insertion_o          : one-cycle pulse on committed 0->1 presence
//   card_removal_o            : one-cycle pulse on committed 1->0 presence
// -----------------------------------------------------------------------------
module sd_card_detect #(
  parameter int unsigned DebounceCycles = 65536,
  parameter int unsigned SyncStages     = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sd_cd_ni,
  input  logic sd_wp_i,
  input  logic cd_test_sel_i,
  input  logic cd_test_level_i,
  output logic card_inserted_o,
  output logic card_state_stable_o,
  output logic card_detect_pin_level_o,
  output logic write_protect_pin_level_o,
  output logic card_insertion_o,
  output logic card_removal_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  generate
    if (DebounceCycles < 2) begin : g_bad_debounce
      $error("sd_card_detect: DebounceCycles must be at least 2");
    end
    if (SyncStages < 2) begin : g_bad_sync
      $error("sd_card_detect: SyncStages must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SETTLE   = 2'd0,
    ST_STABLE   = 2'd1,
    ST_DEBOUNCE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. The cd chain resets to 1 so the block starts out
  // seeing "no card" and the inverted pin level output reads 0 in reset.
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0] cd_sync_q;
  logic [SyncStages-1:0] wp_sync_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbours; blocking here would collapse
  // the synchroniser chain into a single stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cd_sync_q <= '1;
      wp_sync_q <= '0;
    end else begin
      cd_sync_q <= {cd_sync_q[SyncStages-2:0], sd_cd_ni};
      wp_sync_q <= {wp_sync_q[SyncStages-2:0], sd_wp_i};
    end
  end

  // Presence sample fed to the debouncer. The test level bypasses the
  // synchroniser (it comes from a register in our own clock domain) but is
  // still debounced, so toggling the select looks like an ordinary change.
  logic sample;
  assign sample = cd_test_sel_i ? cd_test_level_i : ~cd_sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic            ins_q;
  logic [CntW-1:0] cnt_q;
  logic            s_prev_q;
  logic            stable_q;
  logic            ins_pulse_q;
  logic            rem_pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_SETTLE;
      ins_q       <= 1'b0;
      cnt_q       <= '0;
      s_prev_q    <= 1'b0;
      stable_q    <= 1'b0;
      ins_pulse_q <= 1'b0;
      rem_pulse_q <= 1'b0;
    end else begin
      ins_pulse_q <= 1'b0;
      rem_pulse_q <= 1'b0;
      s_prev_q    <= sample;

      case (state_q)
        // After reset the committed level is unknown: wait for a run of
        // equal samples, then adopt it. Only a present card raises an event.
        ST_SETTLE: begin
          if (sample == s_prev_q) begin
            if (cnt_q == CntFull) begin
              ins_q       <= sample;
              cnt_q       <= '0;
              state_q     <= ST_STABLE;
              stable_q    <= 1'b1;
              ins_pulse_q <= sample;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end else begin
            // The first sample of a new run counts as one.
            cnt_q <= CntOne;
          end
        end

        ST_STABLE: begin
          if (sample != ins_q) begin
            state_q  <= ST_DEBOUNCE;
            cnt_q    <= CntOne;
            stable_q <= 1'b0;
          end else begin
            cnt_q <= '0;
          end
        end

        ST_DEBOUNCE: begin
          if (sample == ins_q) begin
            // Glitch shorter than the debounce window: drop it silently.
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            stable_q <= 1'b1;
          end else if (cnt_q == CntLast) begin
            ins_q       <= sample;
            state_q     <= ST_STABLE;
            cnt_q       <= '0;
            stable_q    <= 1'b1;
            ins_pulse_q <= sample;
            rem_pulse_q <= ~sample;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        default: begin
          state_q  <= ST_SETTLE;
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end
      endcase
    end
  end

  assign card_inserted_o           = ins_q;
  assign card_state_stable_o       = stable_q;
  assign card_insertion_o          = ins_pulse_q;
  assign card_removal_o            = rem_pulse_q;
  assign card_detect_pin_level_o   = ~cd_sync_q[SyncStages-1];
  assign write_protect_pin_level_o = wp_sync_q[SyncStages-1];

endmodule
